// File: rtl/decryptor_pkg.sv
// rtl/decryptor_pkg.sv - shared types and helpers for the decryptor receive path
package decryptor_pkg;

    typedef enum logic {IDLE, ACTIVE} ctl_st_t;

    // Widest word the rotate helper handles; callers zero-extend into it and truncate back.
    localparam int MAX_W = 64;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic [MAX_W-1:0] rotr(input logic [MAX_W-1:0] word,
                                               input int unsigned       key,
                                               input int unsigned       width);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] w;
        mask = {MAX_W{1'b1}} >> (MAX_W - width);
        w    = word & mask;
        // key==0 shifts the wrap-around term past the word width, where the mask discards it.
        return ((w >> key) | (w << (width - key))) & mask;
    endfunction

endpackage

// File: rtl/decryptor_fifo.sv
// rtl/decryptor_fifo.sv - ciphertext word buffer with registered count and empty/full flags
module decryptor_fifo
    import decryptor_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int BUF_SIZE = 16,
    localparam int PTR_W   = ptr_w(BUF_SIZE),
    localparam int CNT_W   = $clog2(BUF_SIZE) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_req,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_req,
    output logic [WIDTH-1:0] rd_data,
    output logic             wr_acc,
    output logic             rd_acc,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [BUF_SIZE];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next;

    // Flags sampled before the edge: a full FIFO refuses the write even if a read frees a slot.
    assign wr_acc  = wr_req && !full;
    assign rd_acc  = rd_req && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CNT_W'(BUF_SIZE));
        end
    end

endmodule

// File: rtl/decryptor.sv
// rtl/decryptor.sv - receive-side FIFO returning rotate-right decoded plaintext on read
// Optional sticky overflow/underflow flags under DECRYPTOR_ERR_EN.
module decryptor
    import decryptor_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int BUF_SIZE = 16,
    localparam int KEY_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int CNT_W   = $clog2(BUF_SIZE) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_ld,
    input  logic [KEY_W-1:0] key,
    input  logic             wr_n,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_n,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
`ifdef DECRYPTOR_ERR_EN
    ,
    output logic             ovf,
    output logic             udf
`endif
);

    logic [WIDTH-1:0] rd_data;
    logic             wr_acc;
    logic             rd_acc;
    logic [KEY_W-1:0] key_q;
    logic             key_ok;
    ctl_st_t          ctl_st;
    ctl_st_t          ctl_nxt;

    decryptor_fifo #(
        .WIDTH   (WIDTH),
        .BUF_SIZE(BUF_SIZE)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_req (!wr_n),
        .din    (din),
        .rd_req (!rd_n),
        .rd_data(rd_data),
        .wr_acc (wr_acc),
        .rd_acc (rd_acc),
        .empty  (empty),
        .full   (full),
        .count  (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_st <= IDLE;
        end else begin
            ctl_st <= ctl_nxt;
        end
    end

    // Key changes only while nothing is buffered, so every stored word decodes with the key it was sent under.
    always_comb begin
        ctl_nxt = ctl_st;
        key_ok  = 1'b0;
        case (ctl_st)
            IDLE: begin
                key_ok = key_ld;
                if (wr_acc) begin
                    ctl_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (rd_acc && !wr_acc && (count == CNT_W'(1))) begin
                    ctl_nxt = IDLE;
                end
            end
            default: ctl_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q <= '0;
            dout  <= '0;
        end else begin
            if (key_ok) begin
                key_q <= key;
            end
            if (rd_acc) begin
                dout <= WIDTH'(rotr(MAX_W'(rd_data), 32'(key_q), 32'(WIDTH)));
            end
        end
    end

`ifdef DECRYPTOR_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (!wr_n && full) begin
                ovf <= 1'b1;
            end
            if (!rd_n && empty) begin
                udf <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decryptor.sv
// tb/tb_decryptor.sv - self-checking bench for decryptor: vector table, directed corners, random vs queue model
module tb_decryptor;

    localparam int W = 8;
    localparam int N = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_ld;
    logic [2:0] key;
    logic       wr_n;
    logic [7:0] din;
    logic       rd_n;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic [4:0] count;
`ifdef DECRYPTOR_ERR_EN
    logic       ovf;
    logic       udf;
`endif

    decryptor #(.WIDTH(W), .BUF_SIZE(N)) dut (
        .clk   (clk),
        .reset (reset),
        .key_ld(key_ld),
        .key   (key),
        .wr_n  (wr_n),
        .din   (din),
        .rd_n  (rd_n),
        .dout  (dout),
        .empty (empty),
        .full  (full),
        .count (count)
`ifdef DECRYPTOR_ERR_EN
        ,
        .ovf   (ovf),
        .udf   (udf)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int mq[$];
    int m_key;
    int m_dout;
    bit m_ovf;
    bit m_udf;

    typedef struct {
        bit       wr_n;
        bit [7:0] din;
        bit       rd_n;
        bit       key_ld;
        bit [2:0] key;
        bit [7:0] e_dout;
        int       e_count;
        bit       e_empty;
        bit       e_full;
    } vec_t;

    vec_t tv[7];
    int   orig[N];
    int   x;

    // Plaintext bit i comes from ciphertext bit (i+k) mod 8.
    function automatic int rotr_m(input int w, input int k);
        int r = 0;
        for (int i = 0; i < 8; i++) begin
            if (((w >> ((i + k) % 8)) & 1) != 0) r += (1 << i);
        end
        return r;
    endfunction

    function automatic int rotl_m(input int w, input int k);
        return rotr_m(w, (8 - k) % 8);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("dout", 32'(dout), m_dout);
        check("count", 32'(count), mq.size());
        check("empty", 32'(empty), (mq.size() == 0) ? 1 : 0);
        check("full", 32'(full), (mq.size() == N) ? 1 : 0);
`ifdef DECRYPTOR_ERR_EN
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("udf", 32'(udf), 32'(m_udf));
`endif
    endtask

    task automatic step(input bit w_n, input int d, input bit r_n, input bit kl, input int k);
        int sz = mq.size();
        wr_n   = w_n;
        din    = 8'(d);
        rd_n   = r_n;
        key_ld = kl;
        key    = 3'(k);
        if (!w_n && sz == N) m_ovf = 1'b1;
        if (!r_n && sz == 0) m_udf = 1'b1;
        if (!r_n && sz > 0) m_dout = rotr_m(mq.pop_front(), m_key);
        if (kl && sz == 0) m_key = k;
        if (!w_n && sz < N) mq.push_back(d & 'hFF);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        wr_n   = 1'b1;
        rd_n   = 1'b1;
        key_ld = 1'b0;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mq.delete();
        m_key  = 0;
        m_dout = 0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        compare_all();
    endtask

    initial begin
        reset = 1'b1; key_ld = 1'b0; key = '0; wr_n = 1'b1; din = '0; rd_n = 1'b1;
        do_reset();

        // wr_n din rd_n key_ld key | dout count empty full
        tv[0] = '{1'b1, 8'h00, 1'b1, 1'b1, 3'd3, 8'h00, 0, 1'b1, 1'b0};
        tv[1] = '{1'b0, 8'h8D, 1'b1, 1'b0, 3'd0, 8'h00, 1, 1'b0, 1'b0};
        tv[2] = '{1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'hB1, 0, 1'b1, 1'b0};
        tv[3] = '{1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'hB1, 0, 1'b1, 1'b0};
        tv[4] = '{1'b1, 8'h00, 1'b1, 1'b1, 3'd0, 8'hB1, 0, 1'b1, 1'b0};
        tv[5] = '{1'b0, 8'h8D, 1'b1, 1'b0, 3'd0, 8'hB1, 1, 1'b0, 1'b0};
        tv[6] = '{1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h8D, 0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            step(tv[i].wr_n, int'(tv[i].din), tv[i].rd_n, tv[i].key_ld, int'(tv[i].key));
            check("tv_dout", 32'(dout), 32'(tv[i].e_dout));
            check("tv_count", 32'(count), tv[i].e_count);
            check("tv_empty", 32'(empty), 32'(tv[i].e_empty));
            check("tv_full", 32'(full), 32'(tv[i].e_full));
        end

        // Fill to full with key 5, overflow write dropped, drain in order.
        step(1, 0, 1, 1, 5);
        for (int i = 0; i < N; i++) begin
            orig[i] = int'($urandom_range(0, 255));
            step(0, rotl_m(orig[i], 5), 1, 0, 0);
        end
        check("fill_full", 32'(full), 1);
        check("fill_count", 32'(count), 16);
        step(0, 8'h3C, 1, 0, 0);
        check("drop_count", 32'(count), 16);
        for (int i = 0; i < N; i++) begin
            step(1, 0, 0, 0, 0);
            check("drain_data", 32'(dout), orig[i]);
        end
        check("drain_empty", 32'(empty), 1);

        // Simultaneous read/write at steady occupancy, pointers wrap.
        for (int i = 0; i < 8; i++) step(0, int'($urandom_range(0, 255)), 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, int'($urandom_range(0, 255)), 0, 0, 0);
            check("rw_count", 32'(count), 8);
        end
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0);

        // Key load while words are held is ignored.
        orig[0] = 8'h96; orig[1] = 8'h3B;
        step(0, rotl_m(orig[0], 5), 1, 0, 0);
        step(0, rotl_m(orig[1], 5), 1, 0, 0);
        step(1, 0, 1, 1, 7);
        step(1, 0, 0, 0, 0);
        check("oldkey0", 32'(dout), orig[0]);
        step(1, 0, 0, 0, 0);
        check("oldkey1", 32'(dout), orig[1]);
        step(1, 0, 1, 1, 7);
        step(0, rotl_m(8'hC4, 7), 1, 0, 0);
        step(1, 0, 0, 0, 0);
        check("newkey", 32'(dout), 8'hC4);

        // Reset mid-stream discards words and restores pass-through key.
        for (int i = 0; i < 6; i++) step(0, i * 17, 1, 0, 0);
        do_reset();
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_dout", 32'(dout), 0);
        step(0, 8'hA5, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rst_passthru", 32'(dout), 8'hA5);

`ifdef DECRYPTOR_ERR_EN
        step(1, 0, 0, 0, 0);
        check("udf_set", 32'(udf), 1);
        for (int i = 0; i < N; i++) step(0, i, 1, 0, 0);
        step(0, 8'hFF, 1, 0, 0);
        check("ovf_set", 32'(ovf), 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        check("ovf_hold", 32'(ovf), 1);
        check("udf_hold", 32'(udf), 1);
        do_reset();
        check("ovf_clr", 32'(ovf), 0);
        check("udf_clr", 32'(udf), 0);
`endif

        // Random traffic with write-heavy and read-heavy phases.
        for (int i = 0; i < 400; i++) begin
            if (i % 137 == 136) begin
                do_reset();
            end else begin
                bit wb = ((i / 40) % 2) == 0;
                x = int'($urandom_range(0, 255));
                step(($urandom_range(0, 3) < (wb ? 3 : 1)) ? 1'b0 : 1'b1, x,
                     ($urandom_range(0, 3) < (wb ? 1 : 3)) ? 1'b0 : 1'b1,
                     ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                     int'($urandom_range(0, 7)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
